sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO for same-domain buffering, replacing ad-hoc register queues wherever producer and consumer share a clock. It generalises the team's dual-clock FIFO to a single-clock form and adds:
- a selectable first-word-fall-through (FWFT) read mode;
- an exact occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 33 +++
 rtl/sync_fifo_flags.sv | 95 +++++++++
 tb/tb_sync_fifo_flags.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and depth/count-width helpers.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Count must represent 0..depth inclusive, hence depth+1 states.
  function automatic int unsigned fifo_cnt_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage array: clocked write port, registered and combinational read ports.
module fifo_mem #(
  parameter int unsigned pADDR_WIDTH = 4,
  parameter int unsigned pDATA_WIDTH = 8
) (
  input  logic                   wr_clk,
  input  logic                   wr_en,
  input  logic [pADDR_WIDTH-1:0] wr_addr,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   rd_en,
  input  logic [pADDR_WIDTH-1:0] rd_addr,
  output logic [pDATA_WIDTH-1:0] rd_data,
  output logic [pDATA_WIDTH-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 32'd1 << pADDR_WIDTH;

  logic [pDATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact count, programmable almost flags, sticky errors, optional FWFT.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 4,
  parameter int unsigned pDATA_WIDTH = 8,
  parameter int unsigned pFWFT       = FIFO_MODE_STD,
  parameter int unsigned pAFULL_TH   = (32'd1 << pADDR_WIDTH) - 32'd2,
  parameter int unsigned pAEMPTY_TH  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_push,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_pop,
  output logic [pDATA_WIDTH-1:0] rd_data,
  output logic                   wr_full,
  output logic                   rd_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [pADDR_WIDTH:0]   count,
  output logic                   wr_overflow,
  output logic                   rd_underflow,
  input  logic                   clr_err
);

  localparam int unsigned AW    = pADDR_WIDTH;
  localparam int unsigned DEPTH = fifo_depth(pADDR_WIDTH);
  localparam int unsigned CW    = fifo_cnt_width(DEPTH);

  logic [AW-1:0]          wr_addr;
  logic [AW-1:0]          rd_addr;
  logic                   wr_en;
  logic                   rd_en;
  logic [CW-1:0]          count_nxt;
  logic [pDATA_WIDTH-1:0] mem_rd_q;
  logic [pDATA_WIDTH-1:0] mem_rd_c;

  // Enables and next count are computed from pre-edge flags only.
  always_comb begin
    wr_en     = wr_push & ~wr_full;
    rd_en     = rd_pop & ~rd_empty;
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, count, flags and sticky errors; all flags follow the next-state count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr      <= '0;
      rd_addr      <= '0;
      count        <= '0;
      wr_full      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (wr_en) wr_addr <= wr_addr + AW'(1);
      if (rd_en) rd_addr <= rd_addr + AW'(1);
      count        <= count_nxt;
      wr_full      <= (count_nxt == CW'(DEPTH));
      rd_empty     <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(pAFULL_TH));
      almost_empty <= (count_nxt <= CW'(pAEMPTY_TH));
      // A new error in the same cycle as clr_err keeps the flag set.
      wr_overflow  <= (wr_push & wr_full)  | (wr_overflow  & ~clr_err);
      rd_underflow <= (rd_pop  & rd_empty) | (rd_underflow & ~clr_err);
    end
  end

  fifo_mem #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_mem (
    .wr_clk    (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_clk    (clk),
    .rd_rst    (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (mem_rd_q),
    .rd_data_c (mem_rd_c)
  );

  assign rd_data = (pFWFT == FIFO_MODE_FWFT) ? mem_rd_c : mem_rd_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: standard-mode and FWFT instances driven by the same stimulus.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic       wr_push;
  logic [7:0] wr_data;
  logic       rd_pop;
  logic       clr_err;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  int vectors;
  int errors;

  sync_fifo_flags #(.pADDR_WIDTH(4), .pDATA_WIDTH(8), .pFWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_push(wr_push), .wr_data(wr_data), .rd_pop(rd_pop),
    .rd_data(s_rd_data), .wr_full(s_full), .rd_empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .wr_overflow(s_ovf), .rd_underflow(s_udf),
    .clr_err(clr_err)
  );

  sync_fifo_flags #(.pADDR_WIDTH(4), .pDATA_WIDTH(8), .pFWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_push(wr_push), .wr_data(wr_data), .rd_pop(rd_pop),
    .rd_data(f_rd_data), .wr_full(f_full), .rd_empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .wr_overflow(f_ovf), .rd_underflow(f_udf),
    .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_push = 1'b0; wr_data = '0; rd_pop = 1'b0; clr_err = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    vectors++; if (s_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", s_count); end
    vectors++; if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", s_empty); end
    vectors++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", s_full); end
    vectors++; if (s_ae !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b want 1", s_ae); end
    vectors++; if (s_af !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", s_af); end
    vectors++; if ({s_ovf, s_udf} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {s_ovf, s_udf}); end
    vectors++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", s_rd_data); end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 16; k++) begin
      wr_push = 1'b1; wr_data = 8'(k - 1);
      step();
      vectors++; if (s_count !== 5'(k)) begin errors++; $display("FAIL fill_count k=%0d got %0d want %0d", k, s_count, k); end
      vectors++; if (s_full !== (k == 16)) begin errors++; $display("FAIL fill_full k=%0d got %b want %b", k, s_full, (k == 16)); end
      vectors++; if (s_af !== (k >= 14)) begin errors++; $display("FAIL fill_afull k=%0d got %b want %b", k, s_af, (k >= 14)); end
      vectors++; if (s_ae !== (k <= 1)) begin errors++; $display("FAIL fill_aempty k=%0d got %b want %b", k, s_ae, (k <= 1)); end
      vectors++; if (s_empty !== 1'b0) begin errors++; $display("FAIL fill_empty k=%0d got %b want 0", k, s_empty); end
      vectors++; if (f_rd_data !== 8'h00) begin errors++; $display("FAIL fill_fwft_head k=%0d got %h want 00", k, f_rd_data); end
    end
    wr_data = 8'hEE;
    step();
    wr_push = 1'b0;
    vectors++; if (s_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", s_count); end
    vectors++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", s_ovf); end
    step();
    vectors++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", s_ovf); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    vectors++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", s_ovf); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 16; k++) begin
      rd_pop = 1'b1;
      step();
      vectors++; if (s_rd_data !== 8'(k)) begin errors++; $display("FAIL drain_data k=%0d got %h want %h", k, s_rd_data, 8'(k)); end
      vectors++; if (s_count !== 5'(15 - k)) begin errors++; $display("FAIL drain_count k=%0d got %0d want %0d", k, s_count, 15 - k); end
      vectors++; if (s_empty !== (k == 15)) begin errors++; $display("FAIL drain_empty k=%0d got %b want %b", k, s_empty, (k == 15)); end
      if (k < 15) begin
        vectors++; if (f_rd_data !== 8'(k + 1)) begin errors++; $display("FAIL drain_fwft_head k=%0d got %h want %h", k, f_rd_data, 8'(k + 1)); end
      end
    end
    step();
    rd_pop = 1'b0;
    vectors++; if (s_udf !== 1'b1) begin errors++; $display("FAIL udf_flag got %b want 1", s_udf); end
    vectors++; if (s_count !== 5'd0) begin errors++; $display("FAIL udf_count got %0d want 0", s_count); end
    vectors++; if (s_rd_data !== 8'h0F) begin errors++; $display("FAIL udf_hold got %h want 0f", s_rd_data); end
    step();
    vectors++; if (s_udf !== 1'b1) begin errors++; $display("FAIL udf_sticky got %b want 1", s_udf); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    vectors++; if (s_udf !== 1'b0) begin errors++; $display("FAIL udf_clear got %b want 0", s_udf); end
  endtask

  task automatic test_fwft();
    wr_push = 1'b1; wr_data = 8'hA5;
    step();
    wr_push = 1'b0;
    vectors++; if (f_rd_data !== 8'hA5) begin errors++; $display("FAIL fwft_data got %h want a5", f_rd_data); end
    vectors++; if (f_empty !== 1'b0) begin errors++; $display("FAIL fwft_empty got %b want 0", f_empty); end
    vectors++; if (s_rd_data !== 8'h0F) begin errors++; $display("FAIL std_no_pop_hold got %h want 0f", s_rd_data); end
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
    vectors++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty got %b want 1", f_empty); end
    vectors++; if (s_rd_data !== 8'hA5) begin errors++; $display("FAIL std_pop_data got %h want a5", s_rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wr_val;
    logic [7:0] rd_exp;
    wr_val = 8'h10; rd_exp = 8'h10;
    for (int k = 0; k < 8; k++) begin
      wr_push = 1'b1; wr_data = wr_val; wr_val++;
      step();
    end
    vectors++; if (s_count !== 5'd8) begin errors++; $display("FAIL b2b_prefill got %0d want 8", s_count); end
    for (int k = 0; k < 40; k++) begin
      wr_push = 1'b1; rd_pop = 1'b1; wr_data = wr_val; wr_val++;
      step();
      vectors++; if (s_rd_data !== rd_exp) begin errors++; $display("FAIL b2b_data k=%0d got %h want %h", k, s_rd_data, rd_exp); end
      rd_exp++;
      vectors++; if (s_count !== 5'd8) begin errors++; $display("FAIL b2b_count k=%0d got %0d want 8", k, s_count); end
      vectors++; if (f_rd_data !== rd_exp) begin errors++; $display("FAIL b2b_fwft_head k=%0d got %h want %h", k, f_rd_data, rd_exp); end
    end
    wr_push = 1'b0; rd_pop = 1'b0;
    vectors++; if ({s_ovf, s_udf} !== 2'b00) begin errors++; $display("FAIL b2b_err got %b want 00", {s_ovf, s_udf}); end
    for (int k = 0; k < 8; k++) begin
      rd_pop = 1'b1;
      step();
      vectors++; if (s_rd_data !== rd_exp) begin errors++; $display("FAIL b2b_drain k=%0d got %h want %h", k, s_rd_data, rd_exp); end
      rd_exp++;
    end
    rd_pop = 1'b0;
    vectors++; if (s_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", s_empty); end
  endtask

  task automatic test_full_both();
    for (int k = 0; k < 16; k++) begin
      wr_push = 1'b1; wr_data = 8'(8'h30 + k);
      step();
    end
    wr_data = 8'h99; rd_pop = 1'b1;
    step();
    wr_push = 1'b0; rd_pop = 1'b0;
    vectors++; if (s_count !== 5'd15) begin errors++; $display("FAIL fullboth_count got %0d want 15", s_count); end
    vectors++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL fullboth_ovf got %b want 1", s_ovf); end
    vectors++; if (s_full !== 1'b0) begin errors++; $display("FAIL fullboth_full got %b want 0", s_full); end
    vectors++; if (s_rd_data !== 8'h30) begin errors++; $display("FAIL fullboth_data got %h want 30", s_rd_data); end
    wr_push = 1'b1; wr_data = 8'h40; clr_err = 1'b1;
    step();
    wr_push = 1'b0; clr_err = 1'b0;
    vectors++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL clr_alone got %b want 0", s_ovf); end
    vectors++; if (s_full !== 1'b1) begin errors++; $display("FAIL refill_full got %b want 1", s_full); end
    wr_push = 1'b1; wr_data = 8'h77; clr_err = 1'b1;
    step();
    wr_push = 1'b0; clr_err = 1'b0;
    vectors++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b want 1", s_ovf); end
    for (int k = 0; k < 16; k++) begin
      rd_pop = 1'b1;
      step();
      vectors++; if (s_rd_data !== 8'(8'h31 + k)) begin errors++; $display("FAIL fullboth_drain k=%0d got %h want %h", k, s_rd_data, 8'(8'h31 + k)); end
    end
    rd_pop = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      wr_push = 1'b1; wr_data = 8'(8'h50 + k);
      step();
    end
    wr_push = 1'b0;
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
    vectors++; if (s_count !== 5'd4) begin errors++; $display("FAIL mid_count got %0d want 4", s_count); end
    wr_push = 1'b1; wr_data = 8'h55;
    step();
    wr_push = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++; if (s_count !== 5'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", s_count); end
    vectors++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin errors++; $display("FAIL rstmid_flags got %b want 1100", {s_empty, s_ae, s_full, s_af}); end
    vectors++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", s_rd_data); end
    step();
    rst = 1'b0;
    step();
    vectors++; if (s_empty !== 1'b1) begin errors++; $display("FAIL rstrel_empty got %b want 1", s_empty); end
    wr_push = 1'b1; wr_data = 8'h77;
    step();
    wr_push = 1'b0;
    vectors++; if (f_rd_data !== 8'h77) begin errors++; $display("FAIL rstrel_fwft got %h want 77", f_rd_data); end
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
    vectors++; if (s_rd_data !== 8'h77) begin errors++; $display("FAIL rstrel_std got %h want 77", s_rd_data); end
    vectors++; if (s_empty !== 1'b1) begin errors++; $display("FAIL rstrel_empty2 got %b want 1", s_empty); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_back_to_back();
    test_full_both();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
